// File: rtl/alu_channel_scheduler.sv
// Schedules left/right filter jobs onto one shared ALU: round-robin grant,
// start pulse, bounded wait for completion, result hold with valid/ready.
module alu_channel_scheduler #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        Sclk,
  input  logic        uni_reset_n,
  input  logic        req_L,
  input  logic        req_R,
  output logic        ALU_calc,
  input  logic        ALU_finish,
  input  logic [39:0] alu_data,
  output logic        ch_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] out_data,
  output logic        out_ch,
  output logic        ovr_L,
  output logic        ovr_R,
  output logic        tmo_err,
  input  logic        clr_err
);

  typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} state_e;

  localparam logic [9:0] TMO_CNT = 10'(TIMEOUT);

  state_e      state_q, state_d;
  logic        pend_l_q, pend_l_d;
  logic        pend_r_q, pend_r_d;
  logic        last_q, last_d;
  logic        ch_sel_q, ch_sel_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [39:0] out_data_q, out_data_d;
  logic        out_ch_q, out_ch_d;
  logic        ovr_l_q, ovr_l_d;
  logic        ovr_r_q, ovr_r_d;
  logic        tmo_q, tmo_d;
  logic        grant_vld, grant_ch;
  logic        active_l, active_r;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    last_d     = last_q;
    ch_sel_d   = ch_sel_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    tmo_d      = tmo_q & ~clr_err;
    grant_vld  = 1'b0;
    grant_ch   = 1'b0;

    // A channel's own job is in flight from START until HOLD is released.
    active_l = (state_q != IDLE) && !ch_sel_q;
    active_r = (state_q != IDLE) &&  ch_sel_q;

    unique case (state_q)
      IDLE: begin
        if (pend_l_q || pend_r_q) begin
          grant_vld = 1'b1;
          // On a tie the channel not granted last wins; last_q resets to right.
          grant_ch  = (pend_l_q && pend_r_q) ? ~last_q : pend_r_q;
          ch_sel_d  = grant_ch;
          last_d    = grant_ch;
          cnt_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = cnt_q + 10'd1;
        state_d = BUSY;
      end
      BUSY: begin
        // cnt_q holds the number of BUSY cycles elapsed including this one.
        if (ALU_finish) begin
          out_data_d = alu_data;
          out_ch_d   = ch_sel_q;
          state_d    = HOLD;
        end else if (cnt_q == TMO_CNT) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 10'h3FF) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new request always sets pend, so set beats a coincident grant-clear.
    pend_l_d = req_L | (pend_l_q & ~(grant_vld & ~grant_ch));
    pend_r_d = req_R | (pend_r_q & ~(grant_vld &  grant_ch));
    ovr_l_d  = (ovr_l_q & ~clr_err) | (req_L & (pend_l_q | active_l));
    ovr_r_d  = (ovr_r_q & ~clr_err) | (req_R & (pend_r_q | active_r));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Sclk or negedge uni_reset_n) begin
    if (!uni_reset_n) begin
      state_q    <= IDLE;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      last_q     <= 1'b1;
      ch_sel_q   <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= 1'b0;
      ovr_l_q    <= 1'b0;
      ovr_r_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      last_q     <= last_d;
      ch_sel_q   <= ch_sel_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ovr_l_q    <= ovr_l_d;
      ovr_r_q    <= ovr_r_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ALU_calc  = (state_q == START);
  assign out_valid = (state_q == HOLD);
  assign ch_sel    = ch_sel_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign ovr_L     = ovr_l_q;
  assign ovr_R     = ovr_r_q;
  assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_alu_channel_scheduler.sv
// Directed bench for alu_channel_scheduler: default instance for the
// functional scenarios, a TIMEOUT=8 instance for the abort path.
module tb_alu_channel_scheduler;

  logic        Sclk = 1'b0;
  logic        uni_reset_n = 1'b0;
  logic        req_L = 0, req_R = 0, ALU_finish = 0, out_ready = 0, clr_err = 0;
  logic [39:0] alu_data = '0;
  logic        ALU_calc, ch_sel, out_valid, out_ch, ovr_L, ovr_R, tmo_err;
  logic [39:0] out_data;

  logic        t_req_L = 0, t_req_R = 0, t_finish = 0, t_ready = 0, t_clr = 0;
  logic [39:0] t_alu_data = '0;
  logic        t_calc, t_ch_sel, t_valid, t_out_ch, t_ovr_L, t_ovr_R, t_tmo;
  logic [39:0] t_out_data;

  int errs = 0;
  int checks = 0;

  always #5 Sclk = ~Sclk;

  alu_channel_scheduler dut (
    .Sclk(Sclk), .uni_reset_n(uni_reset_n), .req_L(req_L), .req_R(req_R),
    .ALU_calc(ALU_calc), .ALU_finish(ALU_finish), .alu_data(alu_data),
    .ch_sel(ch_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .ovr_L(ovr_L), .ovr_R(ovr_R),
    .tmo_err(tmo_err), .clr_err(clr_err)
  );

  alu_channel_scheduler #(.TIMEOUT(8)) dut_t (
    .Sclk(Sclk), .uni_reset_n(uni_reset_n), .req_L(t_req_L), .req_R(t_req_R),
    .ALU_calc(t_calc), .ALU_finish(t_finish), .alu_data(t_alu_data),
    .ch_sel(t_ch_sel), .out_valid(t_valid), .out_ready(t_ready),
    .out_data(t_out_data), .out_ch(t_out_ch), .ovr_L(t_ovr_L), .ovr_R(t_ovr_R),
    .tmo_err(t_tmo), .clr_err(t_clr)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic do_reset();
    uni_reset_n = 1'b0;
    req_L = 0; req_R = 0; ALU_finish = 0; out_ready = 0; clr_err = 0; alu_data = '0;
    t_req_L = 0; t_req_R = 0; t_finish = 0; t_ready = 0; t_clr = 0; t_alu_data = '0;
    repeat (2) tick();
    uni_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    uni_reset_n = 1'b0;
    req_L = 1'b1;
    repeat (3) tick();
    checks++; if (ALU_calc !== 1'b0)  begin errs++; $display("FAIL rst_calc: got=%b exp=0", ALU_calc); end
    checks++; if (ch_sel !== 1'b0)    begin errs++; $display("FAIL rst_ch_sel: got=%b exp=0", ch_sel); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got=%b exp=0", out_valid); end
    checks++; if (out_data !== 40'h0) begin errs++; $display("FAIL rst_data: got=%h exp=0", out_data); end
    checks++; if (out_ch !== 1'b0)    begin errs++; $display("FAIL rst_out_ch: got=%b exp=0", out_ch); end
    checks++; if ({ovr_L, ovr_R, tmo_err} !== 3'b000) begin errs++; $display("FAIL rst_flags: got=%b exp=000", {ovr_L, ovr_R, tmo_err}); end
    // Request held through reset must be lost.
    uni_reset_n = 1'b1;
    req_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ALU_calc !== 1'b0) begin errs++; $display("FAIL rst_req_lost cyc%0d: got=%b exp=0", i, ALU_calc); end
    end
  endtask

  task automatic test_single_left();
    do_reset();
    req_L = 1; tick(); req_L = 0;
    tick();
    checks++; if (ALU_calc !== 1'b1) begin errs++; $display("FAIL single_calc: got=%b exp=1", ALU_calc); end
    checks++; if (ch_sel !== 1'b0)   begin errs++; $display("FAIL single_ch_sel: got=%b exp=0", ch_sel); end
    repeat (40) tick();
    checks++; if (ALU_calc !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL single_busy: calc=%b valid=%b exp=0,0", ALU_calc, out_valid); end
    ALU_finish = 1; alu_data = 40'h00_1234_5678; tick(); ALU_finish = 0; alu_data = '0;
    checks++; if (out_valid !== 1'b1)          begin errs++; $display("FAIL single_valid: got=%b exp=1", out_valid); end
    checks++; if (out_data !== 40'h0012345678) begin errs++; $display("FAIL single_data: got=%h exp=0012345678", out_data); end
    checks++; if (out_ch !== 1'b0)             begin errs++; $display("FAIL single_out_ch: got=%b exp=0", out_ch); end
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_release: got=%b exp=0", out_valid); end
    tick();
    checks++; if (ALU_calc !== 1'b0) begin errs++; $display("FAIL single_idle: got=%b exp=0", ALU_calc); end
  endtask

  task automatic test_tie();
    do_reset();
    req_L = 1; req_R = 1; tick(); req_L = 0; req_R = 0;
    tick();
    checks++; if (ALU_calc !== 1'b1 || ch_sel !== 1'b0) begin errs++; $display("FAIL tie_first: calc=%b ch_sel=%b exp=1,0", ALU_calc, ch_sel); end
    tick();
    ALU_finish = 1; alu_data = 40'hAA_0000_0001; tick(); ALU_finish = 0;
    checks++; if (out_valid !== 1'b1 || out_ch !== 1'b0) begin errs++; $display("FAIL tie_hold_l: valid=%b out_ch=%b exp=1,0", out_valid, out_ch); end
    checks++; if (ALU_calc !== 1'b0) begin errs++; $display("FAIL tie_no_calc_hold: got=%b exp=0", ALU_calc); end
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (ALU_calc !== 1'b0) begin errs++; $display("FAIL tie_grant_cycle: got=%b exp=0", ALU_calc); end
    tick();
    checks++; if (ALU_calc !== 1'b1 || ch_sel !== 1'b1) begin errs++; $display("FAIL tie_second: calc=%b ch_sel=%b exp=1,1", ALU_calc, ch_sel); end
    tick();
    ALU_finish = 1; alu_data = 40'hBB_0000_0002; tick(); ALU_finish = 0;
    checks++; if (out_data !== 40'hBB00000002 || out_ch !== 1'b1) begin errs++; $display("FAIL tie_hold_r: data=%h out_ch=%b exp=bb00000002,1", out_data, out_ch); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_overrun();
    int calcs;
    do_reset();
    req_L = 1; tick(); req_L = 0;
    tick(); tick();
    req_L = 1; tick(); req_L = 0;
    checks++; if (ovr_L !== 1'b1 || ovr_R !== 1'b0) begin errs++; $display("FAIL ovr_set: ovr_L=%b ovr_R=%b exp=1,0", ovr_L, ovr_R); end
    ALU_finish = 1; tick(); ALU_finish = 0;
    out_ready = 1; tick(); out_ready = 0;
    calcs = 0;
    for (int i = 0; i < 20; i++) begin
      if (ALU_calc) begin
        calcs++;
        checks++; if (ch_sel !== 1'b0) begin errs++; $display("FAIL ovr_ch_sel: got=%b exp=0", ch_sel); end
      end
      ALU_finish = (i == 3);
      out_ready  = (i == 5);
      tick();
    end
    ALU_finish = 0; out_ready = 0;
    checks++; if (calcs != 1) begin errs++; $display("FAIL ovr_one_more_job: got=%0d exp=1", calcs); end
    clr_err = 1; tick(); clr_err = 0;
    checks++; if (ovr_L !== 1'b0) begin errs++; $display("FAIL ovr_clr: got=%b exp=0", ovr_L); end
    // Overrun on a pending request together with clr_err: set wins.
    req_R = 1; tick();
    clr_err = 1; tick(); req_R = 0; clr_err = 0;
    checks++; if (ovr_R !== 1'b1) begin errs++; $display("FAIL ovr_set_wins: got=%b exp=1", ovr_R); end
  endtask

  task automatic test_timeout();
    do_reset();
    t_req_L = 1; tick(); t_req_L = 0;
    tick();
    checks++; if (t_calc !== 1'b1 || t_ch_sel !== 1'b0) begin errs++; $display("FAIL tmo_start: calc=%b ch_sel=%b exp=1,0", t_calc, t_ch_sel); end
    tick();
    t_req_R = 1; tick(); t_req_R = 0;
    checks++; if (t_ovr_R !== 1'b0) begin errs++; $display("FAIL tmo_no_ovr_r: got=%b exp=0", t_ovr_R); end
    repeat (6) tick();
    checks++; if (t_tmo !== 1'b0) begin errs++; $display("FAIL tmo_early: got=%b exp=0", t_tmo); end
    tick();
    checks++; if (t_tmo !== 1'b1)   begin errs++; $display("FAIL tmo_set: got=%b exp=1", t_tmo); end
    checks++; if (t_valid !== 1'b0) begin errs++; $display("FAIL tmo_valid: got=%b exp=0", t_valid); end
    tick();
    checks++; if (t_calc !== 1'b1 || t_ch_sel !== 1'b1) begin errs++; $display("FAIL tmo_right_served: calc=%b ch_sel=%b exp=1,1", t_calc, t_ch_sel); end
    tick();
    t_clr = 1; tick(); t_clr = 0;
    checks++; if (t_tmo !== 1'b0) begin errs++; $display("FAIL tmo_clr: got=%b exp=0", t_tmo); end
    // Finish on the timeout cycle takes precedence.
    repeat (6) tick();
    t_finish = 1; t_alu_data = 40'h77_8899_AABB; tick(); t_finish = 0;
    checks++; if (t_valid !== 1'b1 || t_tmo !== 1'b0) begin errs++; $display("FAIL tmo_finish_wins: valid=%b tmo=%b exp=1,0", t_valid, t_tmo); end
    checks++; if (t_out_data !== 40'h778899AABB || t_out_ch !== 1'b1) begin errs++; $display("FAIL tmo_finish_data: data=%h ch=%b exp=778899aabb,1", t_out_data, t_out_ch); end
    t_ready = 1; tick(); t_ready = 0;
  endtask

  task automatic test_back_to_back_hold();
    do_reset();
    req_L = 1; tick(); req_L = 0;
    tick(); tick();
    ALU_finish = 1; alu_data = 40'hC0_FFEE_0011; tick(); ALU_finish = 0; alu_data = '0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 40'hC0FFEE0011 || ALU_calc !== 1'b0) begin
        errs++; $display("FAIL hold_stable cyc%0d: valid=%b data=%h calc=%b exp=1,c0ffee0011,0", i, out_valid, out_data, ALU_calc);
      end
      req_R = (i == 3);
      ALU_finish = (i == 10);
      tick();
    end
    req_R = 0; ALU_finish = 0;
    checks++; if (ovr_R !== 1'b0) begin errs++; $display("FAIL hold_ovr_r: got=%b exp=0", ovr_R); end
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (out_valid !== 1'b0 || ALU_calc !== 1'b0) begin errs++; $display("FAIL hold_release: valid=%b calc=%b exp=0,0", out_valid, ALU_calc); end
    tick();
    checks++; if (ALU_calc !== 1'b1 || ch_sel !== 1'b1) begin errs++; $display("FAIL hold_right_start: calc=%b ch_sel=%b exp=1,1", ALU_calc, ch_sel); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_R = 1; tick(); req_R = 0;
    tick(); tick(); tick();
    checks++; if (ch_sel !== 1'b1) begin errs++; $display("FAIL midrst_pre_ch_sel: got=%b exp=1", ch_sel); end
    #2 uni_reset_n = 1'b0;
    #1;
    checks++; if (ALU_calc !== 1'b0 || ch_sel !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL midrst_outs: calc=%b ch_sel=%b valid=%b exp=0,0,0", ALU_calc, ch_sel, out_valid); end
    checks++; if (out_data !== 40'h0 || out_ch !== 1'b0 || {ovr_L, ovr_R, tmo_err} !== 3'b000) begin errs++; $display("FAIL midrst_rest: data=%h ch=%b flags=%b exp=0", out_data, out_ch, {ovr_L, ovr_R, tmo_err}); end
    tick();
    uni_reset_n = 1'b1;
    ALU_finish = 1; alu_data = 40'hDE_AD00_BEEF; tick(); ALU_finish = 0;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_finish_ignored: got=%b exp=0", out_valid); end
    tick();
    checks++; if (ALU_calc !== 1'b0) begin errs++; $display("FAIL midrst_pend_cleared: got=%b exp=0", ALU_calc); end
    req_L = 1; tick(); req_L = 0;
    tick();
    checks++; if (ALU_calc !== 1'b1 || ch_sel !== 1'b0) begin errs++; $display("FAIL midrst_first_req: calc=%b ch_sel=%b exp=1,0", ALU_calc, ch_sel); end
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_tie();
    test_overrun();
    test_timeout();
    test_back_to_back_hold();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_channel_scheduler.md
ALU_CHANNEL_SCHEDULER -- requirements
Module: alu_channel_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 1023: max Sclk cycles allowed in BUSY before abort.
REQ-002 Sclk  input  1  rising-edge system clock.
REQ-003 uni_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_L  input  1  one-cycle pulse: left-channel sample written, filter run required.
REQ-005 req_R  input  1  one-cycle pulse: right-channel sample written, filter run required.
REQ-006 ALU_calc  output  1  one-cycle start pulse to the shared ALU.
REQ-007 ALU_finish  input  1  one-cycle done pulse from the ALU; alu_data valid in that cycle.
REQ-008 alu_data  input  40  ALU output_data.
REQ-009 ch_sel  output  1  memory-bank select for the running job: 0 = left, 1 = right.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream output serializer accepts the result.
REQ-012 out_data  output  40  captured result.
REQ-013 out_ch  output  1  channel of out_data: 0 = L, 1 = R.
REQ-014 ovr_L, ovr_R  output  1 each  sticky overrun flags.
REQ-015 tmo_err  output  1  sticky timeout flag.
REQ-016 clr_err  input  1  synchronous clear of ovr_L, ovr_R and tmo_err.

Function
REQ-017 pend_L and pend_R SHALL be set by req_L and req_R respectively, and cleared when that channel is granted; when set and clear coincide, set SHALL win.
REQ-018 A req on a channel whose pend bit is already 1, or whose job is currently active (START, BUSY or HOLD), SHALL set that channel's ovr bit; the request is merged, not queued twice.
REQ-019 The state machine SHALL have the states IDLE, START, BUSY and HOLD.
REQ-020 IDLE: if any pend bit is set, grant a channel by round-robin, load ch_sel, and go to START; left has priority after reset and on the first tie.
REQ-021 Round-robin: on a tie, grant the channel not granted last.
REQ-022 START: ALU_calc=1 for exactly one cycle, then go to BUSY.
REQ-023 BUSY: count cycles; on ALU_finish, capture alu_data into out_data and ch_sel into out_ch, and go to HOLD.
REQ-024 BUSY with count==TIMEOUT and no ALU_finish: set tmo_err, discard the job, go to IDLE; ALU_finish in that same cycle takes precedence over the timeout.
REQ-025 HOLD: out_valid=1, with out_data and out_ch stable; out_valid && out_ready transfers the result and goes to IDLE (no combinational ready-to-valid path).
REQ-026 ch_sel SHALL stay constant from START through the end of BUSY.
REQ-027 ALU_finish outside BUSY SHALL be ignored.
REQ-028 Minimum service latency from req (pend set) to out_valid is 3 cycles plus the ALU run time (IDLE grant, START, BUSY).
REQ-029 clr_err coincident with a new error event: the set SHALL win.
REQ-030 The busy counter is 10 bits wide (TIMEOUT <= 1023), is cleared on entry to START, and SHALL NOT wrap.

Reset
REQ-031 On uni_reset_n low, the block SHALL go to IDLE immediately (including mid-BUSY or mid-HOLD) and clear pend_L and pend_R.
REQ-032 Reset values: ALU_calc=0, ch_sel=0, out_valid=0, out_data=0, out_ch=0, ovr_L=0, ovr_R=0, tmo_err=0; last-grant pointer set so that left wins the first tie.
REQ-033 After release, the first req SHALL be honoured normally; requests during reset are lost.

Verification
REQ-034 Single left job: req_L pulse; ALU_finish 40 cycles after ALU_calc with alu_data=40'h00_1234_5678 -> out_valid with out_data=40'h0012345678, out_ch=0; out_ready=1 returns the FSM to IDLE.
REQ-035 Simultaneous req_L and req_R after reset -> left served first, then right; the ALU_calc pulses are separated by at least the HOLD handshake; ch_sel toggles 0 then 1.
REQ-036 req_L again while the left job is BUSY -> ovr_L=1; exactly one further left job runs; clr_err=1 -> ovr_L=0.
REQ-037 TIMEOUT=8, ALU_finish never asserted -> tmo_err=1 eight cycles after entering BUSY; out_valid stays 0; a pending right request is then served.
REQ-038 out_ready held 0 for 20 cycles in HOLD, with req_R arriving meanwhile -> out_data stable; no ALU_calc until the transfer; right job starts after the transfer.
REQ-039 uni_reset_n asserted mid-BUSY -> all outputs at reset values that cycle; a later ALU_finish is ignored.
